// File: rtl/card_shuffler.sv
`default_nettype none
// card_shuffler: LFSR-driven Fisher-Yates shuffle of 8 card pairs, written out to card memory port B.
// Optional macro CARD_SHUFFLER_BYPASS_EN writes the board unshuffled.  Rev 1.0
module card_shuffler (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] seed,
  output logic       Busy,
  output logic       Done,
  output logic       WriteEnable,
  output logic [3:0] dataLoc,
  output logic [5:0] dataOut
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PICK  = 3'd2,
    SWAP  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] LFSR_INIT = 8'hA5;

  state_t     state;
  logic [2:0] deck [16];
  logic [7:0] lfsr;
  logic [3:0] i;
  logic [3:0] j;
  logic [3:0] k;

  logic [7:0] lfsr_step;
  logic [3:0] k_next;
  logic [2:0] first_card;

  assign lfsr_step  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign k_next     = k + 4'd1;
  // deck[0] as it will read after the final (i == 1) swap lands on the same edge
  assign first_card = (j == 4'd0) ? deck[i] : deck[0];

  // Deck storage carries no reset; LOAD always rebuilds it before use.
  always_ff @(posedge Clk) begin
    if (state == LOAD) begin
      for (int n = 0; n < 16; n++) begin
        deck[n] <= 3'(n >> 1);
      end
    end else if (state == SWAP) begin
      deck[i] <= deck[j];
      deck[j] <= deck[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      lfsr        <= LFSR_INIT;
      i           <= 4'd0;
      j           <= 4'd0;
      k           <= 4'd0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      WriteEnable <= 1'b0;
      dataLoc     <= 4'd0;
      dataOut     <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= LOAD;
            Busy  <= 1'b1;
            lfsr  <= (seed == 8'd0) ? LFSR_INIT : seed;
          end
        end
        LOAD: begin
          i <= 4'd15;
`ifdef CARD_SHUFFLER_BYPASS_EN
          state       <= WRITE;
          k           <= 4'd0;
          WriteEnable <= 1'b1;
          dataLoc     <= 4'd0;
          dataOut     <= {3'b010, 3'd0};
`else
          state <= PICK;
`endif
        end
        PICK: begin
          lfsr <= lfsr_step;
          if (lfsr_step[3:0] <= i) begin
            j     <= lfsr_step[3:0];
            state <= SWAP;
          end
        end
        SWAP: begin
          if (i == 4'd1) begin
            state       <= WRITE;
            k           <= 4'd0;
            WriteEnable <= 1'b1;
            dataLoc     <= 4'd0;
            dataOut     <= {3'b010, first_card};
          end else begin
            i     <= i - 4'd1;
            state <= PICK;
          end
        end
        WRITE: begin
          if (k == 4'd15) begin
            state       <= DONE;
            WriteEnable <= 1'b0;
            dataLoc     <= 4'd0;
            dataOut     <= 6'd0;
            Done        <= 1'b1;
          end else begin
            k       <= k_next;
            dataLoc <= k_next;
            dataOut <= {3'b010, deck[k_next]};
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
          Busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          Busy        <= 1'b0;
          Done        <= 1'b0;
          WriteEnable <= 1'b0;
          dataLoc     <= 4'd0;
          dataOut     <= 6'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
